// File: rtl/known_ch_table.sv
// -----------------------------------------------------------------------------
// known_ch_table
//
// Cluster-head table for the EER-RL node. Holds up to DEPTH cluster-head
// advertisements (ID, hop count, Q-value). A re-advertised ID is updated in
// place. After every successful insertion or update the table is walked once
// more to pick the best cluster head: highest Q-value, then fewest hops, then
// lowest index. The packet parser feeds adverts in. The routing and forwarding
// logic consumes chosenCH / hopsfromCH.
//
// Optional feature macro: KCH_EVICT_EN
//   When defined, an advert that arrives while the table is full and that
//   matches no entry may replace the worst entry. The new advert must be
//   strictly better: higher Q, or equal Q with fewer hops.
//   When undefined, such an advert is always rejected.
//
// Parameters
//   WORD_WIDTH  width of ID, hops, Q-value and limit fields
//   DEPTH       number of table entries (>= 2)
//   IDX_W       entry index width, derived from DEPTH
//
// Ports
//   clk         system clock
//   nrst        asynchronous active-low reset
//   HB_reset    heartbeat: clear table, latch HB_CHlimit (synchronous)
//   HB_CHlimit  max cluster heads tracked this round (0 or > DEPTH = DEPTH)
//   en_KCH      one-cycle strobe, fCH_* fields valid
//   fCH_ID      advertised cluster-head ID (all-ones is reserved)
//   fCH_Hops    hops to that cluster head
//   fCH_QValue  Q-value, unsigned Q2.14
//   chosenCH    selected cluster-head ID, all-ones = none
//   hopsfromCH  hops of the selected cluster head, all-ones = none
//   chosenQ     Q-value of the selected cluster head
//   kch_count   number of valid entries
//   kch_busy    an advert is being processed
//   kch_done    one-cycle pulse: outputs updated (or advert rejected)
//   kch_drop    one-cycle pulse: advert rejected or ignored
// -----------------------------------------------------------------------------
module known_ch_table #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] HB_CHlimit,
  input  logic                  en_KCH,
  input  logic [WORD_WIDTH-1:0] fCH_ID,
  input  logic [WORD_WIDTH-1:0] fCH_Hops,
  input  logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic [WORD_WIDTH-1:0] chosenCH,
  output logic [WORD_WIDTH-1:0] hopsfromCH,
  output logic [WORD_WIDTH-1:0] chosenQ,
  output logic [IDX_W:0]        kch_count,
  output logic                  kch_busy,
  output logic                  kch_done,
  output logic                  kch_drop
);

  localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WORD_WIDTH-1:0] DEPTH_W  = WORD_WIDTH'(DEPTH);
  localparam logic [IDX_W:0]        DEPTH_C  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]        CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_SELECT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Table storage
  logic                  ent_valid [DEPTH];
  logic [WORD_WIDTH-1:0] ent_id    [DEPTH];
  logic [WORD_WIDTH-1:0] ent_hops  [DEPTH];
  logic [WORD_WIDTH-1:0] ent_q     [DEPTH];

  // Advert being processed
  logic [WORD_WIDTH-1:0] hold_id;
  logic [WORD_WIDTH-1:0] hold_hops;
  logic [WORD_WIDTH-1:0] hold_q;

  logic [WORD_WIDTH-1:0] limit_reg;
  logic [IDX_W:0]        eff_lim;
  logic [IDX_W-1:0]      idx;
  logic                  last_idx;

  // Scan results
  logic                  match_found;
  logic [IDX_W-1:0]      match_idx;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
`ifdef KCH_EVICT_EN
  logic                  worst_found;
  logic [IDX_W-1:0]      worst_idx;
  logic [WORD_WIDTH-1:0] worst_q;
  logic [WORD_WIDTH-1:0] worst_hops;
  logic                  cand_worse;
`endif
  logic                  evict_ok;
  logic                  write_reject;
  logic                  reject;

  // Select results
  logic                  best_found;
  logic [WORD_WIDTH-1:0] best_id;
  logic [WORD_WIDTH-1:0] best_hops;
  logic [WORD_WIDTH-1:0] best_q;
  logic                  cand_better;

  // Entry currently visited by SCAN / SELECT
  logic                  cur_valid;
  logic [WORD_WIDTH-1:0] cur_id;
  logic [WORD_WIDTH-1:0] cur_hops;
  logic [WORD_WIDTH-1:0] cur_q;

  assign cur_valid = ent_valid[idx];
  assign cur_id    = ent_id[idx];
  assign cur_hops  = ent_hops[idx];
  assign cur_q     = ent_q[idx];

  // A limit of zero, or one larger than the table, means "use every entry".
  always_comb begin
    eff_lim = DEPTH_C;
    if (limit_reg != '0 && limit_reg <= DEPTH_W) begin
      eff_lim = limit_reg[IDX_W:0];
    end
  end

  assign last_idx = ({1'b0, idx} == (eff_lim - CNT_ONE));

  // Best: higher Q wins, then fewer hops. Ties on both keep the earlier
  // (lower-index) candidate because we only replace on strict improvement.
  assign cand_better = !best_found ||
                       (cur_q > best_q) ||
                       ((cur_q == best_q) && (cur_hops < best_hops));

`ifdef KCH_EVICT_EN
  // Worst: lower Q loses, then more hops. Full ties move to the later
  // (higher-index) entry, hence the >= on hops.
  assign cand_worse = !worst_found ||
                      (cur_q < worst_q) ||
                      ((cur_q == worst_q) && (cur_hops >= worst_hops));

  assign evict_ok = worst_found &&
                    ((hold_q > worst_q) ||
                     ((hold_q == worst_q) && (hold_hops < worst_hops)));
`else
  assign evict_ok = 1'b0;
`endif

  assign write_reject = !match_found && !free_found && !evict_ok;
  assign kch_busy     = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A heartbeat aborts whatever is in progress.
  always_comb begin
    state_next = state;
    if (HB_reset) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (en_KCH && (fCH_ID != ALL_ONES)) state_next = S_SCAN;
        S_SCAN:   if (last_idx) state_next = S_WRITE;
        S_WRITE:  state_next = write_reject ? S_DONE : S_SELECT;
        S_SELECT: if (last_idx) state_next = S_DONE;
        S_DONE:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: table storage, scan/select bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_id[i]    <= '0;
        ent_hops[i]  <= '0;
        ent_q[i]     <= '0;
      end
      hold_id     <= '0;
      hold_hops   <= '0;
      hold_q      <= '0;
      limit_reg   <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
`ifdef KCH_EVICT_EN
      worst_found <= 1'b0;
      worst_idx   <= '0;
      worst_q     <= '0;
      worst_hops  <= '0;
`endif
      reject      <= 1'b0;
      best_found  <= 1'b0;
      best_id     <= ALL_ONES;
      best_hops   <= ALL_ONES;
      best_q      <= '0;
      chosenCH    <= ALL_ONES;
      hopsfromCH  <= ALL_ONES;
      chosenQ     <= '0;
      kch_count   <= '0;
      kch_done    <= 1'b0;
      kch_drop    <= 1'b0;
    end else if (HB_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
      limit_reg  <= HB_CHlimit;
      idx        <= '0;
      kch_count  <= '0;
      chosenCH   <= ALL_ONES;
      hopsfromCH <= ALL_ONES;
      chosenQ    <= '0;
      kch_done   <= 1'b0;
      kch_drop   <= 1'b0;
    end else begin
      kch_done <= 1'b0;
      kch_drop <= 1'b0;

      // Strobes that arrive mid-operation are discarded but reported.
      if (en_KCH && (state != S_IDLE)) begin
        kch_drop <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (en_KCH) begin
            if (fCH_ID == ALL_ONES) begin
              kch_drop <= 1'b1;
            end else begin
              hold_id     <= fCH_ID;
              hold_hops   <= fCH_Hops;
              hold_q      <= fCH_QValue;
              idx         <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
`ifdef KCH_EVICT_EN
              worst_found <= 1'b0;
`endif
            end
          end
        end

        S_SCAN: begin
          if (cur_valid) begin
            if (!match_found && (cur_id == hold_id)) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
`ifdef KCH_EVICT_EN
            if (cand_worse) begin
              worst_found <= 1'b1;
              worst_idx   <= idx;
              worst_q     <= cur_q;
              worst_hops  <= cur_hops;
            end
`endif
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= last_idx ? '0 : idx + IDX_ONE;
        end

        S_WRITE: begin
          if (match_found) begin
            ent_hops[match_idx] <= hold_hops;
            ent_q[match_idx]    <= hold_q;
          end else if (free_found) begin
            ent_valid[free_idx] <= 1'b1;
            ent_id[free_idx]    <= hold_id;
            ent_hops[free_idx]  <= hold_hops;
            ent_q[free_idx]     <= hold_q;
            kch_count           <= kch_count + CNT_ONE;
          end
`ifdef KCH_EVICT_EN
          else if (evict_ok) begin
            ent_id[worst_idx]   <= hold_id;
            ent_hops[worst_idx] <= hold_hops;
            ent_q[worst_idx]    <= hold_q;
          end
`endif
          reject     <= write_reject;
          idx        <= '0;
          best_found <= 1'b0;
        end

        S_SELECT: begin
          if (cur_valid && cand_better) begin
            best_found <= 1'b1;
            best_id    <= cur_id;
            best_hops  <= cur_hops;
            best_q     <= cur_q;
          end
          idx <= last_idx ? '0 : idx + IDX_ONE;
        end

        S_DONE: begin
          kch_done <= 1'b1;
          if (reject) begin
            kch_drop <= 1'b1;
          end else if (best_found) begin
            chosenCH   <= best_id;
            hopsfromCH <= best_hops;
            chosenQ    <= best_q;
          end else begin
            chosenCH   <= ALL_ONES;
            hopsfromCH <= ALL_ONES;
            chosenQ    <= '0;
          end
        end

        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_known_ch_table.sv
// -----------------------------------------------------------------------------
// tb_known_ch_table
//
// Directed testbench for known_ch_table with DEPTH=8 and WORD_WIDTH=16.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, so the DUT sees stable inputs at each rising edge. Expected values are
// hand-computed. They follow KCH_EVICT_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_known_ch_table;

  logic        clk;
  logic        nrst;
  logic        HB_reset;
  logic [15:0] HB_CHlimit;
  logic        en_KCH;
  logic [15:0] fCH_ID;
  logic [15:0] fCH_Hops;
  logic [15:0] fCH_QValue;
  logic [15:0] chosenCH;
  logic [15:0] hopsfromCH;
  logic [15:0] chosenQ;
  logic [3:0]  kch_count;
  logic        kch_busy;
  logic        kch_done;
  logic        kch_drop;

  int checks = 0;
  int errors = 0;

  known_ch_table #(
    .WORD_WIDTH(16),
    .DEPTH(8)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .HB_reset   (HB_reset),
    .HB_CHlimit (HB_CHlimit),
    .en_KCH     (en_KCH),
    .fCH_ID     (fCH_ID),
    .fCH_Hops   (fCH_Hops),
    .fCH_QValue (fCH_QValue),
    .chosenCH   (chosenCH),
    .hopsfromCH (hopsfromCH),
    .chosenQ    (chosenQ),
    .kch_count  (kch_count),
    .kch_busy   (kch_busy),
    .kch_done   (kch_done),
    .kch_drop   (kch_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse the heartbeat for one cycle. Entered and left on a falling edge.
  task automatic hb_pulse(input logic [15:0] limit);
    HB_reset   = 1'b1;
    HB_CHlimit = limit;
    @(negedge clk);
    HB_reset   = 1'b0;
  endtask

  // Strobe one advert and wait (bounded) for kch_done. lat counts falling
  // edges after the sampling edge; saw_drop notes any drop pulse on the way.
  task automatic send_advert(input logic [15:0] id, input logic [15:0] hops,
                             input logic [15:0] q, output int lat,
                             output bit saw_drop);
    en_KCH     = 1'b1;
    fCH_ID     = id;
    fCH_Hops   = hops;
    fCH_QValue = q;
    @(negedge clk);
    en_KCH   = 1'b0;
    lat      = 0;
    saw_drop = 1'b0;
    while (lat < 100) begin
      if (kch_drop) saw_drop = 1'b1;
      if (kch_done) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (chosenCH !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL reset_chosenCH got %h exp %h", chosenCH, 16'hFFFF);
    end
    checks++;
    if (hopsfromCH !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL reset_hops got %h exp %h", hopsfromCH, 16'hFFFF);
    end
    checks++;
    if (chosenQ !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_q got %h exp %h", chosenQ, 16'h0000);
    end
    checks++;
    if ({kch_count, kch_busy, kch_done, kch_drop} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_status got %b exp %b",
                         {kch_count, kch_busy, kch_done, kch_drop}, 7'b0);
    end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat; bit drp;
    hb_pulse(16'd3);
    send_advert(16'd23, 16'd2, 16'h3000, lat, drp);
    checks++;
    if (lat !== 8) begin
      errors++; $display("[TB] FAIL single_latency got %0d exp %0d", lat, 8);
    end
    checks++;
    if ({chosenCH, hopsfromCH, chosenQ} !== {16'd23, 16'd2, 16'h3000}) begin
      errors++; $display("[TB] FAIL single_outputs got %0d/%0d/%h exp 23/2/3000",
                         chosenCH, hopsfromCH, chosenQ);
    end
    checks++;
    if (kch_count !== 4'd1 || kch_busy !== 1'b0 || drp !== 1'b0) begin
      errors++; $display("[TB] FAIL single_status got cnt %0d busy %b drop %b exp 1 0 0",
                         kch_count, kch_busy, drp);
    end
    @(negedge clk);
    checks++;
    if (kch_done !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done_pulse got %b exp %b", kch_done, 1'b0);
    end
  endtask

  task automatic test_tiebreak();
    int lat; bit drp;
    send_advert(16'd41, 16'd1, 16'h3000, lat, drp);
    checks++;
    if (lat !== 8 || chosenCH !== 16'd41 || hopsfromCH !== 16'd1) begin
      errors++; $display("[TB] FAIL tie_hops got lat %0d ch %0d hops %0d exp 8 41 1",
                         lat, chosenCH, hopsfromCH);
    end
    send_advert(16'd7, 16'd4, 16'h3800, lat, drp);
    checks++;
    if (chosenCH !== 16'd7 || chosenQ !== 16'h3800) begin
      errors++; $display("[TB] FAIL tie_q got ch %0d q %h exp 7 3800", chosenCH, chosenQ);
    end
    checks++;
    if (kch_count !== 4'd3) begin
      errors++; $display("[TB] FAIL tie_count got %0d exp %0d", kch_count, 3);
    end
  endtask

  task automatic test_update();
    int lat; bit drp;
    send_advert(16'd7, 16'd4, 16'h1000, lat, drp);
    checks++;
    if (kch_count !== 4'd3) begin
      errors++; $display("[TB] FAIL update_count got %0d exp %0d", kch_count, 3);
    end
    checks++;
    if ({chosenCH, hopsfromCH, chosenQ} !== {16'd41, 16'd1, 16'h3000}) begin
      errors++; $display("[TB] FAIL update_outputs got %0d/%0d/%h exp 41/1/3000",
                         chosenCH, hopsfromCH, chosenQ);
    end
  endtask

  task automatic test_full();
    int lat; bit drp;
    int exp_lat; bit exp_drp;
    logic [15:0] exp_ch, exp_hops, exp_q, exp_ch2;
`ifdef KCH_EVICT_EN
    exp_lat = 8; exp_drp = 1'b0;
    exp_ch = 16'd55; exp_hops = 16'd1; exp_q = 16'h3C00;
    exp_ch2 = 16'd55;
`else
    exp_lat = 5; exp_drp = 1'b1;
    exp_ch = 16'd41; exp_hops = 16'd1; exp_q = 16'h3000;
    exp_ch2 = 16'd7;
`endif
    send_advert(16'd55, 16'd1, 16'h3C00, lat, drp);
    checks++;
    if (lat !== exp_lat || drp !== exp_drp) begin
      errors++; $display("[TB] FAIL full_timing got lat %0d drop %b exp %0d %b",
                         lat, drp, exp_lat, exp_drp);
    end
    checks++;
    if ({chosenCH, hopsfromCH, chosenQ} !== {exp_ch, exp_hops, exp_q}) begin
      errors++; $display("[TB] FAIL full_outputs got %0d/%0d/%h exp %0d/%0d/%h",
                         chosenCH, hopsfromCH, chosenQ, exp_ch, exp_hops, exp_q);
    end
    checks++;
    if (kch_count !== 4'd3) begin
      errors++; $display("[TB] FAIL full_count got %0d exp %0d", kch_count, 3);
    end
    // ID 7 is still present without eviction (in-place update wins). With
    // eviction it was replaced, so 7 now displaces ID 23 (equal Q, more hops).
    send_advert(16'd7, 16'd4, 16'h3800, lat, drp);
    checks++;
    if (chosenCH !== exp_ch2 || kch_count !== 4'd3 || drp !== 1'b0) begin
      errors++; $display("[TB] FAIL full_followup got ch %0d cnt %0d drop %b exp %0d 3 0",
                         chosenCH, kch_count, drp, exp_ch2);
    end
  endtask

  task automatic test_abort();
    bit seen_done, seen_drop;
    hb_pulse(16'd3);
    en_KCH = 1'b1; fCH_ID = 16'd23; fCH_Hops = 16'd2; fCH_QValue = 16'h3000;
    @(negedge clk);
    en_KCH = 1'b0;
    checks++;
    if (kch_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_busy got %b exp %b", kch_busy, 1'b1);
    end
    @(negedge clk);
    en_KCH = 1'b1; fCH_ID = 16'd99;
    @(negedge clk);
    en_KCH = 1'b0;
    checks++;
    if (kch_drop !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_drop got %b exp %b", kch_drop, 1'b1);
    end
    @(negedge clk);
    checks++;
    if (kch_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_drop_pulse got %b exp %b", kch_drop, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    // Now mid-SELECT: heartbeat together with a strobe.
    HB_reset = 1'b1; HB_CHlimit = 16'd3;
    en_KCH = 1'b1; fCH_ID = 16'd77;
    @(negedge clk);
    HB_reset = 1'b0; en_KCH = 1'b0;
    seen_done = 1'b0; seen_drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (kch_done) seen_done = 1'b1;
      if (kch_drop) seen_drop = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 1'b0 || seen_drop !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_pulses got done %b drop %b exp 0 0",
                         seen_done, seen_drop);
    end
    checks++;
    if ({chosenCH, hopsfromCH, chosenQ} !== {16'hFFFF, 16'hFFFF, 16'h0000} ||
        kch_count !== 4'd0 || kch_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_state got %h/%h/%h cnt %0d busy %b exp ffff/ffff/0000 0 0",
                         chosenCH, hopsfromCH, chosenQ, kch_count, kch_busy);
    end
  endtask

  task automatic test_reserved();
    bit seen_done;
    en_KCH = 1'b1; fCH_ID = 16'hFFFF; fCH_Hops = 16'd1; fCH_QValue = 16'h4000;
    @(negedge clk);
    en_KCH = 1'b0;
    checks++;
    if (kch_drop !== 1'b1 || kch_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reserved_drop got drop %b busy %b exp 1 0",
                         kch_drop, kch_busy);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kch_done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || kch_count !== 4'd0 || chosenCH !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL reserved_state got done %b cnt %0d ch %h exp 0 0 ffff",
                         seen_done, kch_count, chosenCH);
    end
  endtask

  task automatic test_limit(input logic [15:0] limit);
    int lat; bit drp;
    logic [15:0] q;
    hb_pulse(limit);
    for (int i = 1; i <= 8; i++) begin
      q = 16'(i) << 10;
      send_advert(16'(i), 16'(i), q, lat, drp);
      checks++;
      if (lat !== 18 || drp !== 1'b0) begin
        errors++; $display("[TB] FAIL limit%0d_insert%0d got lat %0d drop %b exp 18 0",
                           limit, i, lat, drp);
      end
    end
    checks++;
    if (kch_count !== 4'd8 || {chosenCH, hopsfromCH, chosenQ} !== {16'd8, 16'd8, 16'h2000}) begin
      errors++; $display("[TB] FAIL limit%0d_fill got cnt %0d %0d/%0d/%h exp 8 8/8/2000",
                         limit, kch_count, chosenCH, hopsfromCH, chosenQ);
    end
    // Lower Q than every entry, so it is rejected with or without eviction.
    send_advert(16'd9, 16'd1, 16'h0100, lat, drp);
    checks++;
    if (lat !== 10 || drp !== 1'b1 || kch_count !== 4'd8 || chosenCH !== 16'd8) begin
      errors++; $display("[TB] FAIL limit%0d_ninth got lat %0d drop %b cnt %0d ch %0d exp 10 1 8 8",
                         limit, lat, drp, kch_count, chosenCH);
    end
  endtask

  initial begin
    nrst = 1'b0; HB_reset = 1'b0; HB_CHlimit = '0; en_KCH = 1'b0;
    fCH_ID = '0; fCH_Hops = '0; fCH_QValue = '0;
    test_reset();
    test_single();
    test_tiebreak();
    test_update();
    test_full();
    test_abort();
    test_reserved();
    test_limit(16'd0);
    test_limit(16'd20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/known_ch_table.md
# known_ch_table

Parametrised cluster-head table for the EER-RL node, successor to the single-entry known-CH block. Stores up to DEPTH cluster-head advertisements (ID, hop count, Q-value), updates entries in place on re-advertisement, and after every insertion selects the best cluster head by highest Q-value with hop-count tie-break. Sits between the packet parser (heartbeat / CH-advert fields) and the routing/forwarding logic that consumes `chosenCH` and `hopsfromCH`.

## Interface
- WORD_WIDTH, 16: width of ID, hops, Q-value, limit
- DEPTH, 8: number of table entries (≥2)
- IDX_W, $clog2(DEPTH): entry index width (derived, do not override)

- clk  in  1  system clock
- nrst  in  1  asynchronous, active-low reset
- HB_reset  in  1  heartbeat received: clear table, latch HB_CHlimit
- HB_CHlimit  in  WORD_WIDTH  max CHs to track this round
- en_KCH  in  1  one-cycle strobe: fCH_* fields valid
- fCH_ID  in  WORD_WIDTH  advertised CH ID (all-ones reserved)
- fCH_Hops  in  WORD_WIDTH  hops to that CH
- fCH_QValue  in  WORD_WIDTH  Q-value, unsigned Q2.14 (16'h4000 = 1.0)
- chosenCH  out  WORD_WIDTH  selected CH ID, all-ones = none
- hopsfromCH  out  WORD_WIDTH  hops of selected CH, all-ones = none
- chosenQ  out  WORD_WIDTH  Q-value of selected CH
- kch_count  out  IDX_W+1  valid entries
- kch_busy  out  1  operation in progress
- kch_done  out  1  one-cycle pulse: outputs updated
- kch_drop  out  1  one-cycle pulse: advert rejected

## Operation
- Effective limit L = DEPTH if latched limit is 0 or > DEPTH, else latched limit.
- FSM: IDLE → SCAN → WRITE → SELECT → DONE → IDLE.
- IDLE: en_KCH captures fCH_* into holding registers, go SCAN, kch_busy=1. Reserved ID (all-ones): no capture, kch_drop pulse, stay IDLE.
- SCAN: visit entries 0..L-1, one per cycle; record first ID match, first free slot, and worst valid entry (lowest Q; equal Q → more hops; equal both → higher index).
- WRITE: match → overwrite hops and Q; else free slot → insert, kch_count+1; else full → see Configuration. Rejected advert: kch_drop pulse, skip to DONE without changing outputs.
- SELECT: visit entries 0..L-1; best = highest Q; equal Q → fewer hops; equal both → lower index. All comparisons unsigned.
- DONE: register best into chosenCH/hopsfromCH/chosenQ, kch_done=1, kch_busy=0 next cycle.
- en_KCH while kch_busy=1: ignored, kch_drop pulse same cycle as strobe+1.
- HB_reset (synchronous, highest priority, any state): invalidate all entries, kch_count=0, outputs to reset values, latch HB_CHlimit, FSM → IDLE; aborted operation gives no kch_done. HB_reset and en_KCH same cycle: en_KCH ignored, no drop.
- Entries beyond index L-1 never written or read.

## Timing
- Reset (nrst low): chosenCH=all-ones, hopsfromCH=all-ones, chosenQ=0, kch_count=0, kch_busy=0, kch_done=0, kch_drop=0, latched limit=0, all entries invalid, FSM IDLE.
- en_KCH sampled at edge E: kch_busy high from E; SCAN L cycles, WRITE 1, SELECT L, DONE 1; kch_done high in the cycle after edge E+2L+2, outputs valid same cycle and held until next DONE or HB_reset.
- Rejected in WRITE: kch_drop and kch_done both pulse at edge E+L+2 (DONE follows WRITE directly).
- kch_drop/kch_done are single-cycle, never held.

## Configuration
- KCH_EVICT_EN defined: table full, no match → replace worst entry if new Q > worst Q, or equal Q and fewer hops; otherwise reject (kch_drop).
- Undefined: table full, no match → always reject (kch_drop); table contents unchanged.

## Test plan
- Reset, HB_reset with limit 3, advert ID 23/hops 2/Q 16'h3000 → kch_done after 2·3+2 cycles, chosenCH=23, hopsfromCH=2, chosenQ=16'h3000, kch_count=1.
- Adverts 23/2/16'h3000, 41/1/16'h3000, 7/4/16'h3800 → chosenCH 23, then 41 (hops tie-break), then 7; kch_count=3.
- Re-advert 7/4/16'h1000 after above → in-place update, kch_count stays 3, chosenCH=41.
- Limit 3 full, advert 55/1/16'h3C00: with KCH_EVICT_EN → replaces lowest-Q entry, chosenCH=55; without → kch_drop pulse, outputs unchanged.
- HB_reset mid-SELECT, en_KCH during busy, ID 16'hFFFF advert → no kch_done, outputs all-ones/0, count 0; kch_drop pulses for busy and reserved cases.
- HB_CHlimit=0 and =20 with DEPTH=8 → DEPTH=8 entries accepted, 9th advert handled as full.
